// File: rtl/jxfer_pkg.sv
// jxfer_pkg: shared types and helpers for the register-transfer sequencer.
package jxfer_pkg;
  localparam int NREGS = 4;
  localparam int REG_IDX_W = 2;
  typedef enum logic [1:0] {IDLE, ENABLE, SET, HOLD} state_t;
  function automatic logic [NREGS-1:0] dec(input logic [REG_IDX_W-1:0] i);
    return {{(NREGS-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/jrr_arb2.sv
// jrr_arb2: two-way round-robin arbiter; pointer moves past the winner on accept.
module jrr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic ptr;
  always_comb grant = &valid ? (ptr ? 2'b10 : 2'b01) : valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (accept) ptr <= grant[0];
endmodule

// File: rtl/jxfer_ctrl.sv
// jxfer_ctrl: arbitrates two copy requesters and sequences en/set pulses on the
// latch-register bank; all bank-facing outputs come straight from flops.
module jxfer_ctrl
  import jxfer_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [3:0]       req_src,
  input  logic [3:0]       req_dst,
  output logic [1:0]       req_ready,
  output logic [NREGS-1:0] reg_en,
  output logic [NREGS-1:0] reg_set,
  output logic             busy,
  output logic             done,
  output logic             done_id
);
  state_t state;
  logic [1:0] grant, src_in, dst_in, src, dst;
  logic accept, gid, id;
  jrr_arb2 u_arb (
    .clk(clk), .rst_n(rst_n), .valid(req_valid), .accept(accept), .grant(grant)
  );
  always_comb begin
    req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
    accept    = |(req_valid & req_ready);
    gid       = grant[1];
    src_in    = gid ? req_src[3:2] : req_src[1:0];
    dst_in    = gid ? req_dst[3:2] : req_dst[1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      id      <= 1'b0;
      reg_en  <= '0;
      reg_set <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state  <= ENABLE;
            src    <= src_in;
            dst    <= dst_in;
            id     <= gid;
            reg_en <= dec(src_in);
            busy   <= 1'b1;
          end
        end
        // a self-copy would close a transparent latch loop, so it never sets
        ENABLE: begin
          state   <= SET;
          reg_set <= (src == dst) ? '0 : dec(dst);
        end
        SET: begin
          state   <= HOLD;
          reg_set <= '0;
        end
        HOLD: begin
          state   <= IDLE;
          reg_en  <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          done_id <= id;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jxfer_ctrl.sv
// tb_jxfer_ctrl: table-driven transfers, reset corner case and random traffic,
// with a grant/latency model feeding a done scoreboard.
module tb_jxfer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [3:0] req_src = '0, req_dst = '0;
  logic [1:0] req_ready;
  logic [3:0] reg_en, reg_set, prev_en = '0;
  logic busy, done, done_id;
  int n_chk = 0, n_fail = 0, cyc = 0, m_cnt = 0, n_acc = 0;
  logic m_ptr = 1'b0;
  typedef struct {logic [1:0] valid; logic [3:0] src, dst; logic id; logic [3:0] en, set;} vec_t;
  typedef struct {logic id; int acc;} exp_t;
  exp_t sb[$];
  vec_t tbl[8];

  jxfer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_ready(req_ready), .reg_en(reg_en), .reg_set(reg_set), .busy(busy), .done(done),
    .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] m_grant(input logic [1:0] v, input logic p);
    return (v == 2'b11) ? (p ? 2'b10 : 2'b01) : v;
  endfunction

  // reference model: grant, pointer and 3-cycle busy window, accepts pushed to scoreboard
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ptr <= 1'b0;
      m_cnt <= 0;
      sb.delete();
    end else begin
      cyc <= cyc + 1;
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (|req_valid) begin
        sb.push_back('{m_grant(req_valid, m_ptr) == 2'b10, cyc});
        m_ptr <= m_grant(req_valid, m_ptr) != 2'b10;
        m_cnt <= 3;
        n_acc <= n_acc + 1;
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("ready", {30'd0, req_ready}, {30'd0, (m_cnt == 0) ? m_grant(req_valid, m_ptr) : 2'b00});
      chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      chk("en_onehot", $countones(reg_en) <= 1, 1);
      chk("set_onehot", $countones(reg_set) <= 1, 1);
      chk("set_after_en", {31'd0, (|reg_set) && !(|prev_en)}, 0);
      prev_en <= reg_en;
      if (done) begin
        if (sb.size() == 0) chk("done_spurious", 1, 0);
        else begin
          chk("done_id", {31'd0, done_id}, {31'd0, sb[0].id});
          chk("done_cycle", cyc, sb[0].acc + 4);
          void'(sb.pop_front());
        end
      end else if (sb.size() != 0 && cyc > sb[0].acc + 4) begin
        chk("done_missing", 0, 1);
        void'(sb.pop_front());
      end
    end else prev_en <= '0;

  task automatic xfer(input vec_t v);
    req_valid = v.valid;
    req_src = v.src;
    req_dst = v.dst;
    @(negedge clk) chk("tbl_ready", {30'd0, req_ready}, {30'd0, 2'b01 << v.id});
    @(posedge clk) #1;
    req_valid[v.id] = 1'b0;
    {req_src, req_dst} = 8'($urandom);
    @(negedge clk);
    chk("c1_en", {28'd0, reg_en}, {28'd0, v.en});
    chk("c1_set", {28'd0, reg_set}, 0);
    @(posedge clk) #1;
    {req_src, req_dst} = 8'($urandom);
    @(negedge clk);
    chk("c2_en", {28'd0, reg_en}, {28'd0, v.en});
    chk("c2_set", {28'd0, reg_set}, {28'd0, v.set});
    chk("c2_ready", {30'd0, req_ready}, 0);
    @(posedge clk) #1;
    @(negedge clk);
    chk("c3_en", {28'd0, reg_en}, {28'd0, v.en});
    chk("c3_set", {28'd0, reg_set}, 0);
    @(posedge clk) #1;
  endtask

  initial begin
    int start;
    tbl[0] = '{2'b11, 4'b1000, 4'b0111, 1'b0, 4'b0001, 4'b1000};
    tbl[1] = '{2'b10, 4'b1000, 4'b0111, 1'b1, 4'b0100, 4'b0010};
    tbl[2] = '{2'b11, 4'b1101, 4'b0010, 1'b0, 4'b0010, 4'b0100};
    tbl[3] = '{2'b10, 4'b1101, 4'b0010, 1'b1, 4'b1000, 4'b0001};
    tbl[4] = '{2'b10, 4'b1100, 4'b1100, 1'b1, 4'b1000, 4'b0000};
    tbl[5] = '{2'b01, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0010};
    tbl[6] = '{2'b11, 4'b0110, 4'b0011, 1'b1, 4'b0010, 4'b0001};
    tbl[7] = '{2'b01, 4'b0110, 4'b0011, 1'b0, 4'b0100, 4'b1000};
    req_valid = 2'b11;
    #12;
    chk("rst_ready", {30'd0, req_ready}, 0);
    chk("rst_en", {28'd0, reg_en}, 0);
    chk("rst_set", {28'd0, reg_set}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_done_id", {31'd0, done_id}, 0);
    req_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    for (int i = 0; i < 8; i++) xfer(tbl[i]);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    // abort a transfer while the set pulse is on the bus
    req_valid = 2'b01;
    req_src = 4'b0001;
    req_dst = 4'b0010;
    @(posedge clk) #1 req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk) chk("pre_rst_set", {28'd0, reg_set}, 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {28'd0, reg_en}, 0);
    chk("mid_rst_set", {28'd0, reg_set}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    xfer('{2'b11, 4'b0011, 4'b1000, 1'b0, 4'b1000, 4'b0001});
    xfer('{2'b10, 4'b0011, 4'b1000, 1'b1, 4'b0001, 4'b0100});
    start = n_acc;
    for (int c = 0; c < 20000 && n_acc - start < 1000; c++) begin
      @(posedge clk) #1;
      req_valid = 2'($urandom);
      {req_src, req_dst} = 8'($urandom);
    end
    chk("rand_count", {31'd0, n_acc - start >= 1000}, 1);
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1 chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
